reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port register file for the datapath. It is the successor to the single-write-port file.
- NR combinational read ports and two write ports with fixed priority.
- Two parametrised tap outputs (branch target, load function).
- Asynchronous reset of the whole array.
- A sequenced bulk-clear engine that zeroes one register per cycle, so a context switch does not need a wide reset fan-out.

Parameters:
W, 8, data path width in bits
D, 4, address width; depth = 2**D registers
NR, 3, number of read ports (1..8)
TAP0_ADDR, 14, register driven on tap0 (branch target)
TAP1_ADDR, 15, register driven on tap1 (load function)

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high; clears array and control state
raddr  input  NR*D  read addresses; port i = raddr[i*D +: D]
rdata  output  NR*W  read data; port i = rdata[i*W +: W]
we0  input  1  write enable, port 0 (high priority)
waddr0  input  D  write address, port 0
wdata0  input  W  write data, port 0
we1  input  1  write enable, port 1 (low priority)
waddr1  input  D  write address, port 1
wdata1  input  W  write data, port 1
clear_req  input  1  single-cycle request to start bulk clear
busy  output  1  high while clear sequence runs
clear_done  output  1  one-cycle pulse on final clear cycle
tap0  output  W  registers[TAP0_ADDR], combinational
tap1  output  W  registers[TAP1_ADDR], combinational

Behaviour:
- Reset (async, high):
  - all 2**D registers = 0
  - FSM = IDLE, clear counter = 0
  - busy = 0, clear_done = 0
  - rdata and taps therefore read 0
- Reads: combinational, zero latency. rdata[i] = registers[raddr[i]] (see Optional Feature). Taps are always array contents, never bypassed.
- Writes (IDLE only): on a CLK edge with weN high, registers[waddrN] <= wdataN.
  - Both enabled, same address: port 0 wins; port 1 write dropped.
  - Both enabled, different addresses: both commit in the same cycle.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req = 1 at a CLK edge; counter <= 0.
  - In CLEAR, each cycle: registers[counter] <= 0, counter <= counter + 1.
  - CLEAR -> IDLE at the edge where counter = 2**D-1 is written; counter wraps to 0.
  - Total clear length is exactly 2**D cycles.
- busy = (state == CLEAR), registered. It is high from the cycle after clear_req is sampled through the last zeroing cycle.
- clear_done = busy && counter == 2**D-1 (combinational from state), high for one cycle.
- clear_req and write collisions:
  - clear_req while busy: ignored, no restart.
  - clear_req together with we0/we1 in IDLE: the writes commit at that edge; the clear then begins and zeroes them.
  - we0/we1 while busy: dropped, no array change.
- Reads during CLEAR return current array contents: already-cleared entries read 0, later entries keep their old values.
- Reset asserted mid-clear: array zeroed immediately, FSM = IDLE, busy = 0, no clear_done pulse.
- Address widths are exact. No out-of-range addresses exist since depth = 2**D.

Optional Feature:
Macro RF_WRITE_BYPASS_EN.
- Defined: write-through forwarding on read ports.
  - If we0 is high, !busy, and raddr[i] == waddr0, then rdata[i] = wdata0.
  - Else if we1 is high, !busy, and raddr[i] == waddr1, then rdata[i] = wdata1.
  - Else rdata[i] = array contents.
  - Port 0 priority matches the write collision rule. No forwarding while busy.
- Undefined: rdata shows the pre-write array value in the write cycle and the new value from the next cycle. No extra muxing.

Test Plan:
1. Reset high mid-run, then release -> all rdata, tap0, tap1 = 0x00; busy = 0.
2. we0 = 1, waddr0 = 3, wdata0 = 0xA5, same cycle we1 = 1, waddr1 = 3, wdata1 = 0x5A; next cycle raddr[0] = 3 -> rdata[0] = 0xA5 (port 0 wins).
3. Write 0x11 to reg 14 and 0x22 to reg 15 in one cycle via both ports -> next cycle tap0 = 0x11, tap1 = 0x22; rdata for raddr 14/15 match.
4. Fill all 16 registers with nonzero values; pulse clear_req -> busy high for exactly 16 cycles; clear_done high only in the 16th; we0 attempts during busy ignored; afterwards every register reads 0x00.
5. Start clear; assert Reset at clear cycle 5 -> busy drops immediately, no clear_done; array all 0; a new clear_req after release runs the full 16 cycles.
6. With RF_WRITE_BYPASS_EN: we0 = 1, waddr0 = 7, wdata0 = 0x3C, raddr[1] = 7 in the same cycle -> rdata[1] = 0x3C that cycle. Without the macro -> old value that cycle, 0x3C the next.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two prioritised write ports,
// NR combinational read ports, two fixed tap outputs and a sequenced
// bulk-clear engine that zeroes one register per cycle.
// Optional feature: define RF_WRITE_BYPASS_EN to forward same-cycle write
// data onto the read ports (port 0 has priority, no forwarding while busy).
module reg_file_mp #(
  parameter int W         = 8,
  parameter int D         = 4,
  parameter int NR        = 3,
  parameter int TAP0_ADDR = 14,
  parameter int TAP1_ADDR = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NR*D-1:0]   raddr,
  output logic [NR*W-1:0]   rdata,
  input  logic              we0,
  input  logic [D-1:0]      waddr0,
  input  logic [W-1:0]      wdata0,
  input  logic              we1,
  input  logic [D-1:0]      waddr1,
  input  logic [W-1:0]      wdata1,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic [W-1:0]      tap0,
  output logic [W-1:0]      tap1
);

  localparam int DEPTH = 2 ** D;
  localparam logic [D-1:0] LAST_IDX = {D{1'b1}};
  localparam logic [D-1:0] TAP0_IDX = D'(TAP0_ADDR);
  localparam logic [D-1:0] TAP1_IDX = D'(TAP1_ADDR);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [D-1:0]   clear_cnt;
  logic [D-1:0]   clear_cnt_next;
  logic [W-1:0]   regs [DEPTH];

  // Control state register: clear FSM state and the clear address counter.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      clear_cnt <= '0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
    end
  end

  // Next-state logic: a clear request is only honoured from IDLE, and the
  // sequence ends on the edge that zeroes the last register (counter wraps).
  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next     = CLEAR;
          clear_cnt_next = '0;
        end
      end
      CLEAR: begin
        clear_cnt_next = clear_cnt + 1'b1;
        if (clear_cnt == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next     = IDLE;
        clear_cnt_next = '0;
      end
    endcase
  end

  assign busy       = (state == CLEAR);
  assign clear_done = busy && (clear_cnt == LAST_IDX);

  // Storage array: async clear on reset, one register zeroed per cycle while
  // clearing, otherwise both write ports with port 0 winning on collision.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (busy) begin
      regs[clear_cnt] <= '0;
    end else begin
      if (we1 && !(we0 && (waddr0 == waddr1))) begin
        regs[waddr1] <= wdata1;
      end
      if (we0) begin
        regs[waddr0] <= wdata0;
      end
    end
  end

  // Read ports are purely combinational; taps always show stored contents.
  for (genvar p = 0; p < NR; p++) begin : g_read
    logic [D-1:0] rd_addr;
    assign rd_addr = raddr[p*D +: D];

    // Per-port read mux, optionally forwarding same-cycle write data.
    always_comb begin
      rdata[p*W +: W] = regs[rd_addr];
`ifdef RF_WRITE_BYPASS_EN
      if (!busy && we0 && (rd_addr == waddr0)) begin
        rdata[p*W +: W] = wdata0;
      end else if (!busy && we1 && (rd_addr == waddr1)) begin
        rdata[p*W +: W] = wdata1;
      end
`else
`endif
    end
  end

  assign tap0 = regs[TAP0_IDX];
  assign tap1 = regs[TAP1_IDX];

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized, scoreboard-checked bench for reg_file_mp.
// Stimulus pushes expected outputs into a queue; a negedge monitor drains it.
module tb_reg_file_mp;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int NR    = 3;
  localparam int DEPTH = 16;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [NR*D-1:0] raddr;
  logic [NR*W-1:0] rdata;
  logic            we0;
  logic [D-1:0]    waddr0;
  logic [W-1:0]    wdata0;
  logic            we1;
  logic [D-1:0]    waddr1;
  logic [W-1:0]    wdata1;
  logic            clear_req;
  logic            busy;
  logic            clear_done;
  logic [W-1:0]    tap0;
  logic [W-1:0]    tap1;

  reg_file_mp #(.W(W), .D(D), .NR(NR), .TAP0_ADDR(14), .TAP1_ADDR(15)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .raddr      (raddr),
    .rdata      (rdata),
    .we0        (we0),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .we1        (we1),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .tap0       (tap0),
    .tap1       (tap1)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  typedef struct {
    int         kind;
    int         port;
    logic [W-1:0] exp_val;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus "clear in progress" bookkeeping.
  logic [W-1:0] mem [DEPTH];
  bit clearing;
  int clear_pos;

  function automatic logic [NR*D-1:0] pack_raddr(input int a0, input int a1, input int a2);
    logic [NR*D-1:0] r;
    r = '0;
    r[0*D +: D] = D'(a0);
    r[1*D +: D] = D'(a1);
    r[2*D +: D] = D'(a2);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    clearing  = 0;
    clear_pos = 0;
  endfunction

  // Edge behaviour of the model, evaluated with the inputs of the ending cycle.
  function automatic void step_model();
    if (clearing) begin
      mem[clear_pos] = '0;
      clear_pos++;
      if (clear_pos == DEPTH) begin
        clearing  = 0;
        clear_pos = 0;
      end
    end else begin
      if (we1) mem[waddr1] = wdata1;
      if (we0) mem[waddr0] = wdata0;
      if (clear_req) begin
        clearing  = 1;
        clear_pos = 0;
      end
    end
  endfunction

  // Expected outputs for the cycle currently being driven.
  function automatic void push_expect();
    exp_t e;
    for (int p = 0; p < NR; p++) begin
      logic [D-1:0] a;
      logic [W-1:0] v;
      a = raddr[p*D +: D];
      v = mem[a];
`ifdef RF_WRITE_BYPASS_EN
      if (!clearing && we0 && a == waddr0) v = wdata0;
      else if (!clearing && we1 && a == waddr1) v = wdata1;
`endif
      e = '{0, p, v, $sformatf("rdata[%0d]@%0d", p, a)};
      exp_q.push_back(e);
    end
    e = '{1, 0, mem[14], "tap0"};
    exp_q.push_back(e);
    e = '{2, 0, mem[15], "tap1"};
    exp_q.push_back(e);
    e = '{3, 0, W'(clearing), "busy"};
    exp_q.push_back(e);
    e = '{4, 0, W'(clearing && clear_pos == DEPTH - 1), "clear_done"};
    exp_q.push_back(e);
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [W-1:0] act;
    case (e.kind)
      0:       act = rdata[e.port*W +: W];
      1:       act = tap0;
      2:       act = tap1;
      3:       act = W'(busy);
      default: act = W'(clear_done);
    endcase
    checks++;
    if (act !== e.exp_val) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual %h, expected %h", e.name, $time, act, e.exp_val);
    end
  endtask

  // Monitor: drain every expectation queued for this cycle at the falling edge.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  // Drive one cycle: inputs, expectations, edge, model update.
  task automatic applyStimulus(input logic w0, input int a0, input int d0,
                               input logic w1, input int a1, input int d1,
                               input logic creq, input logic [NR*D-1:0] ra);
    we0       = w0;
    waddr0    = D'(a0);
    wdata0    = W'(d0);
    we1       = w1;
    waddr1    = D'(a1);
    wdata1    = W'(d1);
    clear_req = creq;
    raddr     = ra;
    push_expect();
    @(posedge CLK);
    if (!Reset) step_model();
    #1;
  endtask

  task automatic idle_read(input int a0, input int a1, input int a2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, pack_raddr(a0, a1, a2));
  endtask

  task automatic rand_read();
    idle_read($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge.
  task automatic do_reset();
    Reset     = 1'b1;
    we0       = 0;
    we1       = 0;
    clear_req = 0;
    raddr     = pack_raddr($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    model_reset();
    #1;
    push_expect();
    @(posedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, i, $urandom_range(1, 255), 0, 0, 0, 0, pack_raddr(i, 14, 15));
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset     = 1'b1;
    we0       = 0;
    we1       = 0;
    waddr0    = '0;
    waddr1    = '0;
    wdata0    = '0;
    wdata1    = '0;
    clear_req = 0;
    raddr     = '0;
    model_reset();
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    // Some random writes, then reset mid-run.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, $urandom_range(0, 15), $urandom_range(1, 255),
                    1, $urandom_range(0, 15), $urandom_range(1, 255), 0,
                    pack_raddr($urandom_range(0, 15), 14, 15));
    end
    do_reset();
    for (int i = 0; i < DEPTH; i += 3) idle_read(i, (i + 1) % DEPTH, (i + 2) % DEPTH);

    // Same-address collision: port 0 wins.
    applyStimulus(1, 3, 8'hA5, 1, 3, 8'h5A, 0, pack_raddr(3, 0, 0));
    idle_read(3, 3, 3);

    // Both ports to the tap registers in one cycle.
    applyStimulus(1, 14, 8'h11, 1, 15, 8'h22, 0, pack_raddr(14, 15, 3));
    idle_read(14, 15, 3);

    // Full clear with writes and repeated requests attempted while busy.
    fill_all();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, pack_raddr(0, 14, 15));
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, $urandom_range(0, 15), $urandom_range(1, 255),
                    1, $urandom_range(0, 15), $urandom_range(1, 255),
                    logic'($urandom_range(0, 1)),
                    pack_raddr(i, $urandom_range(0, 15), 15));
    end
    for (int i = 0; i < DEPTH; i += 3) idle_read(i, (i + 1) % DEPTH, (i + 2) % DEPTH);

    // Reset during clear cycle 5, then a complete clear afterwards.
    fill_all();
    applyStimulus(1, 2, 8'h77, 0, 0, 0, 1, pack_raddr(2, 14, 15));
    for (int i = 0; i < 4; i++) rand_read();
    do_reset();
    for (int i = 0; i < DEPTH; i += 3) idle_read(i, (i + 1) % DEPTH, (i + 2) % DEPTH);
    fill_all();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, pack_raddr(0, 1, 2));
    for (int i = 0; i < DEPTH + 2; i++) rand_read();

    // Same-cycle read of a register being written (bypass or old value).
    applyStimulus(1, 7, 8'h81, 0, 0, 0, 0, pack_raddr(0, 7, 7));
    applyStimulus(1, 7, 8'h3C, 1, 9, 8'h44, 0, pack_raddr(9, 7, 7));
    idle_read(9, 7, 7);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(logic'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255),
                    logic'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255),
                    logic'($urandom_range(0, 39) == 0),
                    pack_raddr($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)));
    end

    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
